bcd_rtc_clock: RTL and testbench

- Parametrised successor to the team's 12-hour BCD wall clock.
- Keeps hours/minutes/seconds as packed BCD, with a runtime-selectable 12h/24h mode.
- Adds a tick prescaler, validated synchronous time load, and an hh:mm alarm with pulse outputs.
- Sits between the system tick generator and the display/alarm controller.

---
 rtl/bcd_rtc_clock.sv | 165 ++++++++++++++++
 tb/tb_bcd_rtc_clock.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_rtc_clock.sv
// Packed-BCD real-time clock: hh:mm:ss with runtime 12h/24h mode, tick prescaler,
// validated synchronous time load and an hh:mm alarm with one-cycle pulse outputs.
module bcd_rtc_clock #(
    parameter int PRESCALE = 1,
    parameter bit ALARM_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       mode_24h,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       load_pm,
    input  logic       alarm_on,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       alarm_hit,
    output logic       load_err
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic        mode_q;
    logic [15:0] presc;

    logic [7:0]  adv_hh, adv_mm, adv_ss, conv_hh;
    logic        adv_pm, adv_min, conv_pm;
    logic        conv, tick_adv, load_ok, alarm_ok, alarm_fire;

    // Both digits must be decimal; BCD ordering matches numeric ordering once they are.
    function automatic logic bcd_le(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    function automatic logic hours_ok(input logic [7:0] h, input logic m24);
        if (m24)
            return bcd_le(h, 8'h23);
        return bcd_le(h, 8'h12) && (h != 8'h00);
    endfunction

    function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_hours(input logic [7:0] h, input logic m24);
        if (m24 && h == 8'h23)
            return 8'h00;
        if (!m24 && h == 8'h12)
            return 8'h01;
        if (h[3:0] == 4'd9)
            return {h[7:4] + 4'd1, 4'd0};
        return {h[7:4], h[3:0] + 4'd1};
    endfunction

    // Digit-wise +12 / -12 keeps every intermediate a legal BCD digit.
    function automatic logic [7:0] to24(input logic [7:0] h, input logic p);
        if (h == 8'h12)
            return p ? 8'h12 : 8'h00;
        if (!p)
            return h;
        if (h[3:0] >= 4'd8)
            return {h[7:4] + 4'd2, h[3:0] - 4'd8};
        return {h[7:4] + 4'd1, h[3:0] + 4'd2};
    endfunction

    function automatic logic [7:0] to12(input logic [7:0] h);
        if (h == 8'h00)
            return 8'h12;
        if (h <= 8'h12)
            return h;
        if (h[3:0] >= 4'd2)
            return {h[7:4] - 4'd1, h[3:0] - 4'd2};
        return {h[7:4] - 4'd2, h[3:0] + 4'd8};
    endfunction

    always_comb begin
        adv_ss  = inc_bcd60(ss);
        adv_min = (ss == 8'h59);
        adv_mm  = mm;
        adv_hh  = hh;
        adv_pm  = pm;
        if (adv_min) begin
            adv_mm = inc_bcd60(mm);
            if (mm == 8'h59) begin
                adv_hh = inc_hours(hh, mode_q);
                if (mode_q)
                    adv_pm = (adv_hh >= 8'h12);
                else if (hh == 8'h11)
                    adv_pm = !pm;
            end
        end
    end

    always_comb begin
        conv     = (mode_24h != mode_q);
        conv_hh  = mode_q ? to12(hh) : to24(hh, pm);
        conv_pm  = mode_q ? (hh >= 8'h12) : pm;
        tick_adv = tick_in && (presc == PRESC_LAST);
        load_ok  = bcd_le(load_ss, 8'h59) && bcd_le(load_mm, 8'h59) && hours_ok(load_hh, mode_q);
        alarm_ok = bcd_le(alarm_mm, 8'h59) && hours_ok(alarm_hh, mode_q);
        // sec_pulse marks that the current time came from a tick, never from a load.
        alarm_fire = ALARM_EN && alarm_on && sec_pulse && alarm_ok &&
                     (hh == alarm_hh) && (mm == alarm_mm) && (ss == 8'h00) &&
                     (mode_q || (pm == alarm_pm));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hh        <= mode_24h ? 8'h00 : 8'h12;
            mm        <= 8'h00;
            ss        <= 8'h00;
            pm        <= 1'b0;
            mode_q    <= mode_24h;
            presc     <= 16'd0;
            sec_pulse <= 1'b0;
            min_pulse <= 1'b0;
            alarm_hit <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            min_pulse <= 1'b0;
            load_err  <= 1'b0;
            alarm_hit <= alarm_fire;
            if (conv) begin
                hh     <= conv_hh;
                pm     <= conv_pm;
                mode_q <= mode_24h;
            end else if (load) begin
                if (load_ok) begin
                    hh    <= load_hh;
                    mm    <= load_mm;
                    ss    <= load_ss;
                    pm    <= mode_q ? (load_hh >= 8'h12) : load_pm;
                    presc <= 16'd0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick_in) begin
                if (tick_adv) begin
                    presc     <= 16'd0;
                    hh        <= adv_hh;
                    mm        <= adv_mm;
                    ss        <= adv_ss;
                    pm        <= adv_pm;
                    sec_pulse <= 1'b1;
                    min_pulse <= adv_min;
                end else begin
                    presc <= presc + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_rtc_clock.sv
// Directed bench for bcd_rtc_clock: vector table for load/mode/rollover behaviour,
// hand sequences for the prescaler, the alarm and a full 12-hour run.
module tb_bcd_rtc_clock;

    logic       clk = 1'b0;
    logic       reset, tick_in, mode_24h, load, load_pm;
    logic [7:0] load_hh, load_mm, load_ss;
    logic       alarm_on, alarm_pm;
    logic [7:0] alarm_hh, alarm_mm;
    logic [7:0] hh, mm, ss;
    logic       pm, sec_pulse, min_pulse, alarm_hit, load_err;

    logic       reset4, tick4, load4;
    logic [7:0] hh4, mm4, ss4;
    logic       pm4, sec4, min4, hit4, err4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_rtc_clock #(.PRESCALE(1), .ALARM_EN(1)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .mode_24h(mode_24h), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
        .alarm_on(alarm_on), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_pm(alarm_pm),
        .hh(hh), .mm(mm), .ss(ss), .pm(pm), .sec_pulse(sec_pulse), .min_pulse(min_pulse),
        .alarm_hit(alarm_hit), .load_err(load_err)
    );

    bcd_rtc_clock #(.PRESCALE(4), .ALARM_EN(0)) dut4 (
        .clk(clk), .reset(reset4), .tick_in(tick4), .mode_24h(mode_24h), .load(load4),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
        .alarm_on(alarm_on), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_pm(alarm_pm),
        .hh(hh4), .mm(mm4), .ss(ss4), .pm(pm4), .sec_pulse(sec4), .min_pulse(min4),
        .alarm_hit(hit4), .load_err(err4)
    );

    typedef struct {
        logic       rst, tk, m24, ld;
        logic [7:0] lhh, lmm, lss;
        logic       lpm;
        logic [7:0] ehh, emm, ess;
        logic       epm, esec, emin, eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic rst, input logic tk, input logic m24, input logic ld,
                               input logic [7:0] lhh, input logic [7:0] lmm, input logic [7:0] lss,
                               input logic lpm, input logic [7:0] ehh, input logic [7:0] emm,
                               input logic [7:0] ess, input logic epm, input logic esec,
                               input logic emin, input logic eerr);
        vec_t r;
        r.rst = rst; r.tk = tk; r.m24 = m24; r.ld = ld;
        r.lhh = lhh; r.lmm = lmm; r.lss = lss; r.lpm = lpm;
        r.ehh = ehh; r.emm = emm; r.ess = ess;
        r.epm = epm; r.esec = esec; r.emin = emin; r.eerr = eerr;
        return r;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
        load_hh = h; load_mm = m; load_ss = s; load_pm = p; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_tick();
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
    endtask

    task automatic tick_p4();
        tick4 = 1'b1;
        step();
        tick4 = 1'b0;
        step();
    endtask

    int sec_cnt, min_cnt;

    initial begin
        reset = 1'b1; reset4 = 1'b1; tick_in = 1'b0; tick4 = 1'b0; mode_24h = 1'b0;
        load = 1'b0; load4 = 1'b0; load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00; load_pm = 1'b0;
        alarm_on = 1'b0; alarm_hh = 8'h00; alarm_mm = 8'h00; alarm_pm = 1'b0;
        step();
        reset = 1'b0; reset4 = 1'b0;

        // PRESCALE=4 instance
        check8("p4 reset hh", hh4, 8'h12);
        for (int i = 0; i < 11; i++) tick_p4();
        check8("p4 ss after 11 ticks", ss4, 8'h02);
        check8("p4 mm after 11 ticks", mm4, 8'h00);
        tick4 = 1'b1;
        step();
        tick4 = 1'b0;
        check8("p4 12th tick ss", ss4, 8'h03);
        check1("p4 12th tick sec", sec4, 1'b1);
        step();
        tick_p4();
        tick_p4();
        load_hh = 8'h12; load_mm = 8'h00; load_ss = 8'h10; load_pm = 1'b0; load4 = 1'b1;
        step();
        load4 = 1'b0;
        check1("p4 load err", err4, 1'b0);
        check8("p4 load ss", ss4, 8'h10);
        for (int i = 0; i < 3; i++) tick_p4();
        check8("p4 3 ticks after load ss", ss4, 8'h10);
        tick4 = 1'b1;
        step();
        tick4 = 1'b0;
        check8("p4 4th tick after load ss", ss4, 8'h11);
        check1("p4 4th tick sec", sec4, 1'b1);
        check1("p4 min", min4, 1'b0);
        check1("p4 pm", pm4, 1'b0);
        check1("p4 alarm tied low", hit4, 1'b0);

        //                rst   tk    m24   ld    lhh    lmm    lss    lpm   ehh    emm    ess    epm   sec   min   err
        vecs.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 8'h13, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 8'h30, 8'h00, 1'b1, 8'h08, 8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h45, 8'h30, 1'b1, 8'h05, 8'h45, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h17, 8'h45, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h17, 8'h45, 8'h31, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 1'b0, 8'h05, 8'h45, 8'h31, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 8'h23, 8'h59, 8'h58, 1'b0, 8'h23, 8'h59, 8'h58, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h23, 8'h59, 8'h59, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h60, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h5A, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 8'h24, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b1, 8'h09, 8'h15, 8'h00, 1'b1, 8'h09, 8'h15, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h09, 8'h15, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h09, 8'h15, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'h59, 8'h59, 1'b1, 8'h11, 8'h59, 8'h59, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h59, 8'h59, 1'b1, 8'h12, 8'h59, 8'h59, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 8'h59, 8'h59, 1'b0, 8'h09, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 8'h19, 8'h59, 8'h59, 1'b0, 8'h19, 8'h59, 8'h59, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h08, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 8'h00, 1'b1, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            reset = vecs[i].rst; tick_in = vecs[i].tk; mode_24h = vecs[i].m24; load = vecs[i].ld;
            load_hh = vecs[i].lhh; load_mm = vecs[i].lmm; load_ss = vecs[i].lss; load_pm = vecs[i].lpm;
            step();
            check8($sformatf("v%0d hh", i), hh, vecs[i].ehh);
            check8($sformatf("v%0d mm", i), mm, vecs[i].emm);
            check8($sformatf("v%0d ss", i), ss, vecs[i].ess);
            check1($sformatf("v%0d pm", i), pm, vecs[i].epm);
            check1($sformatf("v%0d sec_pulse", i), sec_pulse, vecs[i].esec);
            check1($sformatf("v%0d min_pulse", i), min_pulse, vecs[i].emin);
            check1($sformatf("v%0d load_err", i), load_err, vecs[i].eerr);
            check1($sformatf("v%0d alarm_hit", i), alarm_hit, 1'b0);
        end
        reset = 1'b0; tick_in = 1'b0; load = 1'b0;

        // Alarm: 07:00 AM, 12h mode
        alarm_hh = 8'h07; alarm_mm = 8'h00; alarm_pm = 1'b0; alarm_on = 1'b1;
        do_load(8'h06, 8'h59, 8'h58, 1'b0);
        check1("al load no hit", alarm_hit, 1'b0);
        do_tick();
        check1("al 06:59:59 no hit", alarm_hit, 1'b0);
        do_tick();
        check8("al reach hh", hh, 8'h07);
        check1("al advance edge no hit yet", alarm_hit, 1'b0);
        step();
        check1("al hit pulse", alarm_hit, 1'b1);
        step();
        check1("al hit one cycle", alarm_hit, 1'b0);
        do_load(8'h07, 8'h00, 8'h00, 1'b0);
        check1("al direct load edge", alarm_hit, 1'b0);
        step();
        check1("al direct load after", alarm_hit, 1'b0);
        do_load(8'h06, 8'h59, 8'h59, 1'b0);
        do_tick();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check1("al reset kills pulse", alarm_hit, 1'b0);
        check8("al reset hh", hh, 8'h12);
        step();
        check1("al reset after", alarm_hit, 1'b0);
        alarm_pm = 1'b1;
        do_load(8'h06, 8'h59, 8'h59, 1'b0);
        do_tick();
        step();
        check1("al pm mismatch", alarm_hit, 1'b0);
        mode_24h = 1'b1;
        step();
        do_load(8'h06, 8'h59, 8'h59, 1'b0);
        do_tick();
        step();
        check1("al 24h pm ignored", alarm_hit, 1'b1);
        alarm_on = 1'b0;
        do_load(8'h06, 8'h59, 8'h59, 1'b0);
        do_tick();
        step();
        check1("al disarmed", alarm_hit, 1'b0);

        // Full 12h run from reset with tick held high
        mode_24h = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check8("run reset hh", hh, 8'h12);
        check1("run reset pm", pm, 1'b0);
        sec_cnt = 0;
        min_cnt = 0;
        tick_in = 1'b1;
        for (int i = 1; i <= 46800; i++) begin
            step();
            if (sec_pulse) sec_cnt++;
            if (min_pulse) min_cnt++;
            if (i == 3599) begin
                check8("run 12:59:59 hh", hh, 8'h12);
                check8("run 12:59:59 ss", ss, 8'h59);
                check1("run 12:59:59 pm", pm, 1'b0);
            end
            if (i == 3600) begin
                check8("run 01:00:00 hh", hh, 8'h01);
                check1("run 01:00:00 pm held", pm, 1'b0);
            end
            if (i == 43199) begin
                check8("run 11:59:59 hh", hh, 8'h11);
                check8("run 11:59:59 mm", mm, 8'h59);
                check1("run 11:59:59 pm", pm, 1'b0);
            end
            if (i == 43200) begin
                check8("run 12h hh", hh, 8'h12);
                check8("run 12h mm", mm, 8'h00);
                check8("run 12h ss", ss, 8'h00);
                check1("run 12h pm toggled", pm, 1'b1);
                check1("run 12h min_pulse", min_pulse, 1'b1);
            end
            if (i == 46800) begin
                check8("run 01 PM hh", hh, 8'h01);
                check1("run 01 PM pm held", pm, 1'b1);
            end
        end
        tick_in = 1'b0;
        check8("run sec pulses", 8'(sec_cnt / 400), 8'(46800 / 400));
        check8("run min pulses", 8'(min_cnt / 10), 8'(780 / 10));
        check1("run sec count exact", sec_cnt == 46800, 1'b1);
        check1("run min count exact", min_cnt == 780, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
